// File: rtl/kgprisc_instr_decoder.sv
// kgprisc_instr_decoder: registered opcode decoder producing KGPRISC datapath control strobes
// Ports: clk, rst (async active-high), start (run enable), instr[31:0] (opcode [31:26], funct [5:0]);
// outputs Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite, all registered.
// Optional macro ILLEGAL_DETECT_EN adds registered output illegal for unknown opcodes / R-type funct.
module kgprisc_instr_decoder #(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        ALUop,
  output logic        MemWrite,
  output logic        ALUsrc,
  output logic        RegWrite,
  output logic        ra_RegWrite
`ifdef ILLEGAL_DETECT_EN
  ,
  output logic        illegal
`endif
);
  logic [OPW-1:0] w_op;
  logic [FNW-1:0] w_fn;
  logic [7:0]     w_dec;
  logic [7:0]     w_ctl;
  logic [7:0]     r_ctl;
  logic           w_unused;
  assign w_op = instr[31:32-OPW];
  assign w_fn = instr[FNW-1:0];
  assign w_unused = ^{instr[25:FNW], w_fn};
  // Strobe order: Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite
  always_comb begin
    w_dec = (w_op == OPW'(0))                          ? 8'h12 :
            (w_op == OPW'(1) || w_op == OPW'(2))       ? 8'h06 :
            (w_op == OPW'(3))                          ? 8'h66 :
            (w_op == OPW'(4))                          ? 8'h0C :
            (w_op == OPW'(15))                         ? 8'h81 :
            (w_op >= OPW'(5) && w_op <= OPW'(16))      ? 8'h80 : 8'h00;
  end
`ifdef ILLEGAL_DETECT_EN
  logic w_bad;
  logic r_ill;
  assign w_bad = (w_op > OPW'(16)) || (w_op == OPW'(0) && w_fn > FNW'(9));
  assign w_ctl = w_bad ? 8'h00 : w_dec;
  assign illegal = r_ill;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ill <= 1'b0;
    else     r_ill <= start & w_bad;
`else
  assign w_ctl = w_dec;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ctl <= '0;
    else     r_ctl <= start ? w_ctl : '0;
  assign {Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite} = r_ctl;
endmodule

// File: tb/tb_kgprisc_instr_decoder.sv
// tb_kgprisc_instr_decoder: randomized and directed checks of the decoder against a table model
module tb_kgprisc_instr_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] instr = '0;
  logic Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite;
  logic ill;
  logic [8:0] got;
  logic [8:0] exp_q;
  logic [7:0] tab [64];
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [7:0] BR = 8'h80, MR = 8'h40, M2R = 8'h20, AOP = 8'h10,
                         MW = 8'h08, SRC = 8'h04, RW = 8'h02, RA = 8'h01;
  always #5 clk = ~clk;
  kgprisc_instr_decoder dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr),
    .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg), .ALUop(ALUop),
    .MemWrite(MemWrite), .ALUsrc(ALUsrc), .RegWrite(RegWrite), .ra_RegWrite(ra_RegWrite)
`ifdef ILLEGAL_DETECT_EN
    , .illegal(ill)
`endif
  );
`ifndef ILLEGAL_DETECT_EN
  assign ill = 1'b0;
`endif
  assign got = {ill, Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite};
  initial begin
    for (int i = 0; i < 64; i++) tab[i] = 8'h00;
    tab[0] = RW | AOP;
    tab[1] = RW | SRC;
    tab[2] = RW | SRC;
    tab[3] = MR | M2R | SRC | RW;
    tab[4] = MW | SRC;
    for (int i = 5; i <= 16; i++) tab[i] = BR;
    tab[15] = BR | RA;
  end
  function automatic logic [8:0] model(input logic [31:0] w);
    int op;
    int fn;
    logic bad;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    bad = 1'b0;
`ifdef ILLEGAL_DETECT_EN
    bad = (op > 16) || (op == 0 && fn > 9);
`endif
    return bad ? 9'h100 : {1'b0, tab[op]};
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) exp_q <= '0;
    else     exp_q <= start ? model(instr) : 9'h000;
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (instr %h start %b rst %b)", name, act, req, instr, start, rst);
    end
  endtask
  always @(negedge clk) begin
    check("model", got, exp_q);
    check("inv_mem", {8'h0, MemRead & MemWrite}, 9'h0);
    check("inv_m2r", {8'h0, MemtoReg & ~MemRead}, 9'h0);
    check("inv_ra", {8'h0, ra_RegWrite & (~Branch | RegWrite)}, 9'h0);
  end
  task automatic drive(input logic s, input logic [31:0] w);
    @(posedge clk);
    #2;
    start = s;
    instr = w;
  endtask
  task automatic expect_next(input string name, input logic [8:0] req);
    @(posedge clk);
    #1;
    check(name, got, req);
  endtask
  initial begin
    logic [8:0] bad_exp;
`ifdef ILLEGAL_DETECT_EN
    bad_exp = 9'h100;
`else
    bad_exp = 9'h000;
`endif
    start = 1'b1;
    instr = 32'h0AA00004;
    #1 check("reset_t0", got, 9'h000);
    repeat (3) expect_next("reset_hold", 9'h000);
    drive(1'b1, 32'h0AA00004);
    rst = 1'b0;
    expect_next("addi", 9'h006);
    drive(1'b1, 32'h02B5A800); expect_next("radd", 9'h012);
    drive(1'b1, 32'h0C000000); expect_next("lw", 9'h066);
    drive(1'b1, 32'h10000000); expect_next("sw", 9'h00C);
    drive(1'b1, 32'h3C000000); expect_next("call", 9'h181 & 9'h0FF);
    drive(1'b1, 32'h1C000000); expect_next("bz", 9'h080);
    drive(1'b1, 32'hFC000000); expect_next("op3f", bad_exp);
    drive(1'b0, 32'h0AA00004);
    repeat (3) expect_next("idle", 9'h000);
    drive(1'b1, 32'h0AA00004); expect_next("start_rise", 9'h006);
    drive(1'b0, 32'h0AA00004); expect_next("start_fall", 9'h000);
    drive(1'b1, 32'h0AA00004);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", got, 9'h000);
    drive(1'b1, 32'h02B5A800);
    rst = 1'b0;
    expect_next("post_rst", 9'h012);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) instr[31:26] = 6'($urandom_range(0, 18));
      if ($urandom_range(0, 3) == 0) instr[5:0] = 6'($urandom_range(0, 11));
      start = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kgprisc_instr_decoder.md
Name: kgprisc_instr_decoder

Overview:
Main control decoder for the KGPRISC single-issue datapath. It decodes the 32-bit instruction word into one-bit datapath control strobes that drive the register file, ALU operand mux, data memory and PC branch logic. Outputs are registered and are qualified by a `start` run-enable from the top-level controller.

Parameters:
- OPW, 6, opcode field width; opcode = instr[31:26].
- FNW, 6, funct field width; funct = instr[5:0]. Not decoded into strobes; used only by the optional legality check.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run enable; decode is performed only while high.
- instr  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct, [15:0] imm.
- Branch  out  1  PC is to take a branch / jump target.
- MemRead  out  1  data-memory read.
- MemtoReg  out  1  writeback source is memory (0 = ALU).
- ALUop  out  1  1 = ALU operation comes from funct (R-type); 0 = operation implied by opcode.
- MemWrite  out  1  data-memory write.
- ALUsrc  out  1  ALU operand B is sign-extended imm (0 = rt register).
- RegWrite  out  1  write general register rd/rt.
- ra_RegWrite  out  1  write return-address register (ra = PC+4).

Behaviour:
- Reset: rst=1 asynchronously clears all eight outputs to 0. They stay 0 while rst is high.
- Latency: outputs are registered. On the rising edge where start=1, outputs take the decode of the instr value sampled at that edge. Latency is 1 clock and there is no pipelining beyond that register.
- start=0 at a rising edge: all outputs are loaded with 0 (idle/NOP). They are not held.
- Decode table by opcode; listed strobes are 1 and all others are 0:
  - 000000 R-type ALU (add, comp, and, xor, shll, shrl, shllv, shrlv, shra, shrav): RegWrite, ALUop.
  - 000001 compi: RegWrite, ALUsrc.
  - 000010 addi: RegWrite, ALUsrc.
  - 000011 lw: MemRead, MemtoReg, ALUsrc, RegWrite.
  - 000100 sw: MemWrite, ALUsrc.
  - 000101 b (unconditional): Branch.
  - 000110 br (jump register): Branch.
  - 000111 through 001110 conditional branches (bz, bnz, bcy, bncy, bs, bns, bv, bnv): Branch. The condition is evaluated outside this block.
  - 001111 call: Branch, ra_RegWrite.
  - 010000 ret: Branch.
  - Any other opcode: all outputs 0 (treated as NOP).
- Mutual exclusion invariants, which must hold every cycle:
  - MemRead and MemWrite are never both 1.
  - MemtoReg=1 implies MemRead=1.
  - ra_RegWrite=1 implies Branch=1 and RegWrite=0.
- The register/immediate fields (rs, rt, rd, imm) do not affect any output.
- Reset asserted mid-operation clears the outputs immediately. The first decode after reset release happens at the first rising edge with rst=0 and start=1.

Optional Feature:
- Macro ILLEGAL_DETECT_EN.
- Defined: adds output `illegal` (1 bit, registered, reset 0). It is set with the other strobes when start=1 and either condition holds:
  - the opcode is outside the decode table, or
  - opcode=000000 and funct is not one of 000000–001001.
  In the R-type case the regular R-type strobes are still forced to 0.
- Not defined: no `illegal` port. Undefined R-type funct values decode as normal R-type (RegWrite, ALUop).

Test Plan:
- Reset: rst=1, any instr, start=1 → all outputs 0 immediately and at every edge while rst is held.
- addi: start=1, instr=32'h0AA00004 (opcode 000010, rs=21, imm=4) → after next rising edge RegWrite=1, ALUsrc=1, all others 0.
- R-type add: instr=32'h02B5A800 (opcode 000000, rs=rt=rd=21, funct 0) → next edge RegWrite=1, ALUop=1, ALUsrc=0, others 0.
- Memory: lw (opcode 000011) → MemRead=MemtoReg=ALUsrc=RegWrite=1. sw (opcode 000100) → MemWrite=ALUsrc=1 and RegWrite=0.
- Control flow: call (001111) → Branch=ra_RegWrite=1. bz (000111) → Branch=1 only. Opcode 111111 → all 0, and illegal=1 when ILLEGAL_DETECT_EN is defined.
- Enable: hold start=0 with an addi instr → outputs 0 at every edge. Raise start → decode appears one edge later. Then drop start → outputs return to 0 at the next edge.
